// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1/8E1/8O1 UART transmitter fed by a small
// valid/ready FIFO; frames leave back-to-back while bytes are queued.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 115200,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        rx_clk,
   input  logic                        rst_n,
   input  logic                        tx_data_valid,
   input  logic [7:0]                  tx_data,
   output logic                        tx_data_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        uart_txd,
   output logic                        uart_tx_busy,
   output logic                        uart_tx_done
);

   localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
   localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
   localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
   localparam bit ODD = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t state, state_d;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_cnt, bit_cnt_d;
   logic [7:0]    shreg;
   logic          txd, txd_d;
   logic          push, pop, empty, bit_end, par_bit;

   assign empty         = (level == '0);
   assign tx_data_ready = (level < FULL);
   assign push          = tx_data_valid && tx_data_ready;
   assign bit_end       = (state != IDLE) && (baud_cnt == BAUD_LAST);
   assign par_bit       = ODD ? ~^shreg : ^shreg;
   assign fifo_level    = level;
   assign uart_txd      = txd;

   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:  if (!empty) state_d = START;
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && bit_cnt == 3'd7)
                   state_d = HAS_PAR ? PAR : STOP;
         PAR:   if (bit_end) state_d = STOP;
         STOP:  if (bit_end) state_d = empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // txd is registered from the next state so the line changes
   // on the same edge that enters each bit
   always_comb begin
      pop          = 1'b0;
      uart_tx_done = 1'b0;
      uart_tx_busy = (state != IDLE);
      bit_cnt_d    = '0;
      txd_d        = 1'b1;
      if (state == IDLE || (state == STOP && bit_end))
         pop = !empty;
      if (state == STOP && bit_end)
         uart_tx_done = 1'b1;
      if (state_d == DATA)
         bit_cnt_d = (state == DATA && bit_end) ? bit_cnt + 3'd1 : bit_cnt;
      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg[bit_cnt_d];
         PAR:     txd_d = par_bit;
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         txd      <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            shreg  <= mem[rd_ptr];
         end
         if (push && !pop)      level <= level + (AW + 1)'(1);
         else if (pop && !push) level <= level - (AW + 1)'(1);
         baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 16'd1;
         bit_cnt  <= bit_cnt_d;
         txd      <= txd_d;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

endmodule
